// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: op encodings, FSM states, lane constants.
package mem_access_unit_pkg;

  localparam logic [3:0] MEM_OP_NONE = 4'd0;
  localparam logic [3:0] MEM_OP_LB   = 4'd1;
  localparam logic [3:0] MEM_OP_LBU  = 4'd2;
  localparam logic [3:0] MEM_OP_LH   = 4'd3;
  localparam logic [3:0] MEM_OP_LHU  = 4'd4;
  localparam logic [3:0] MEM_OP_LW   = 4'd5;
  localparam logic [3:0] MEM_OP_SB   = 4'd6;
  localparam logic [3:0] MEM_OP_SH   = 4'd7;
  localparam logic [3:0] MEM_OP_SW   = 4'd8;

  localparam int unsigned LANE_W   = 8;
  localparam logic [31:0] ZEROWORD = 32'h0000_0000;

  typedef enum logic [1:0] {StIdle, StAccess, StDone, StErr} state_e;

  function automatic logic is_store(input logic [3:0] op);
    return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load alignment: picks the addressed byte/halfword of a big-endian word and extends.
module mem_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  a_i,
  input  logic [31:0] w_i,
  output logic [31:0] data_o
);

  logic [LANE_W-1:0]   byte_sel;
  logic [2*LANE_W-1:0] half_sel;

  always_comb begin
    byte_sel = w_i[31:24];
    unique case (a_i)
      2'd0: byte_sel = w_i[31:24];
      2'd1: byte_sel = w_i[23:16];
      2'd2: byte_sel = w_i[15:8];
      2'd3: byte_sel = w_i[7:0];
      default: byte_sel = w_i[31:24];
    endcase
  end

  assign half_sel = a_i[1] ? w_i[15:0] : w_i[31:16];

  always_comb begin
    data_o = ZEROWORD;
    case (op_i)
      MEM_OP_LB:  data_o = {{(32 - LANE_W){byte_sel[LANE_W-1]}}, byte_sel};
      MEM_OP_LBU: data_o = {{(32 - LANE_W){1'b0}}, byte_sel};
      MEM_OP_LH:  data_o = {{(32 - 2 * LANE_W){half_sel[2*LANE_W-1]}}, half_sel};
      MEM_OP_LHU: data_o = {{(32 - 2 * LANE_W){1'b0}}, half_sel};
      MEM_OP_LW:  data_o = w_i;
      default:    data_o = ZEROWORD;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access controller: one load/store per handshake, fixed wait, aligned load response.
// Define MEM_ALIGN_CHECK_EN to trap misaligned halfword/word accesses into the ERR state.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              addr_err_o,
  output logic              stall_o,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_sel,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] resp_q, resp_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept;
  logic              store_q;
  logic [DATA_W-1:0] load_word;

  assign accept  = req_valid && (state_q == StIdle) && (req_op != MEM_OP_NONE);
  assign store_q = is_store(op_q);

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign;

  always_comb begin
    misalign = 1'b0;
    case (req_op)
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: misalign = req_addr[0];
      MEM_OP_LW, MEM_OP_SW:             misalign = (req_addr[1:0] != 2'b00);
      default:                          misalign = 1'b0;
    endcase
  end
`endif

  mem_load_align u_load_align (
    .op_i   (op_q),
    .a_i    (addr_q[1:0]),
    .w_i    (mem_rdata),
    .data_o (load_word)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(WAIT_CYCLES);
`ifdef MEM_ALIGN_CHECK_EN
          state_d = misalign ? StErr : StAccess;
`else
          state_d = StAccess;
`endif
        end
      end
      StAccess: begin
        // Read data is sampled on the same edge that leaves ACCESS.
        if (cnt_q == 4'd0) begin
          state_d = StDone;
          resp_d  = store_q ? ZEROWORD : load_word;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      op_q    <= MEM_OP_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_sel   = 4'b0000;
    mem_wdata = '0;
    if (state_q == StAccess) begin
      mem_ce   = 1'b1;
      mem_we   = store_q;
      mem_addr = {addr_q[DATA_W-1:2], 2'b00};
      case (op_q)
        MEM_OP_SB: begin
          mem_sel   = 4'b1000 >> addr_q[1:0];
          mem_wdata = {4{wdata_q[LANE_W-1:0]}};
        end
        MEM_OP_SH: begin
          mem_sel   = addr_q[1] ? 4'b0011 : 4'b1100;
          mem_wdata = {2{wdata_q[2*LANE_W-1:0]}};
        end
        MEM_OP_SW: begin
          mem_sel   = 4'b1111;
          mem_wdata = wdata_q;
        end
        default: mem_sel = 4'b1111;
      endcase
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign stall_o    = (state_q != StIdle);
  assign resp_valid = (state_q == StDone);
  assign resp_data  = (state_q == StDone) ? resp_q : '0;

`ifdef MEM_ALIGN_CHECK_EN
  assign addr_err_o = (state_q == StErr);
`else
  assign addr_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-lane memory model (WAIT_CYCLES=1 and =0 instances).
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk, rst;
  logic        req_valid, req_ready, resp_valid, addr_err_o, stall_o;
  logic [3:0]  req_op, mem_sel;
  logic [31:0] req_addr, req_wdata, resp_data, mem_addr, mem_wdata, mem_rdata;
  logic        mem_ce, mem_we;

  logic        b_valid, b_ready, b_resp_valid, b_err, b_stall, b_ce, b_we;
  logic [3:0]  b_op, b_sel;
  logic [31:0] b_addr, b_wdata, b_resp_data, b_mem_addr, b_mem_wdata;

  logic [31:0] mem_word [16] = '{default: 32'h0};

  int n_checks = 0;
  int n_fail   = 0;

  // Per-transaction observations filled by do_req
  logic [31:0] r_data, r_mwd;
  logic [3:0]  r_sel;
  int          r_lat, r_we, r_ce, r_err, r_resp, r_busy, r_stall_low;

  mem_access_unit #(.WAIT_CYCLES(1), .DATA_W(32)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .addr_err_o (addr_err_o),
    .stall_o    (stall_o),
    .mem_ce     (mem_ce),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_sel    (mem_sel),
    .mem_rdata  (mem_rdata)
  );

  mem_access_unit #(.WAIT_CYCLES(0), .DATA_W(32)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (b_valid),
    .req_ready  (b_ready),
    .req_op     (b_op),
    .req_addr   (b_addr),
    .req_wdata  (b_wdata),
    .resp_valid (b_resp_valid),
    .resp_data  (b_resp_data),
    .addr_err_o (b_err),
    .stall_o    (b_stall),
    .mem_ce     (b_ce),
    .mem_we     (b_we),
    .mem_addr   (b_mem_addr),
    .mem_wdata  (b_mem_wdata),
    .mem_sel    (b_sel),
    .mem_rdata  (32'hCAFE_F00D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-lane memory, sel[3] = bits 31:24
  assign mem_rdata = mem_word[mem_addr[5:2]];
  always @(posedge clk) begin
    if (mem_ce && mem_we) begin
      for (int l = 0; l < 4; l++)
        if (mem_sel[l]) mem_word[mem_addr[5:2]][8*l +: 8] <= mem_wdata[8*l +: 8];
    end
  end

  task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
    logic fin;
    r_data = '0; r_mwd = '0; r_sel = '0;
    r_lat = 0; r_we = 0; r_ce = 0; r_err = 0; r_resp = 0; r_busy = 99; r_stall_low = 0;
    fin = 1'b0;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = MEM_OP_NONE;
    for (int c = 1; c <= 20; c++) begin
      if (!fin) begin
        if (req_ready) begin
          fin = 1'b1;
          r_busy = c - 1;
        end else begin
          if (stall_o !== 1'b1) r_stall_low++;
          if (mem_ce) begin r_ce++; r_sel = mem_sel; r_mwd = mem_wdata; end
          if (mem_we) r_we++;
          if (addr_err_o) r_err++;
          if (resp_valid) begin r_resp++; r_data = resp_data; r_lat = c; end
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_op = MEM_OP_NONE; req_addr = '0; req_wdata = '0;
    b_valid = 1'b0; b_op = MEM_OP_NONE; b_addr = '0; b_wdata = '0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_checks++;
    if ({stall_o, resp_valid, addr_err_o, mem_ce, mem_we} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000",
                         {stall_o, resp_valid, addr_err_o, mem_ce, mem_we});
    end
    n_checks++;
    if ({mem_sel, mem_addr, mem_wdata, resp_data} !== 100'h0) begin
      n_fail++; $display("FAIL reset_buses: sel %b addr %h wdata %h resp %h want all 0",
                         mem_sel, mem_addr, mem_wdata, resp_data);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_none_op();
    req_valid = 1'b1; req_op = MEM_OP_NONE; req_addr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({req_ready, stall_o, mem_ce} !== 3'b100) begin
        n_fail++; $display("FAIL none_op_idle: got rdy/stall/ce %b want 100",
                           {req_ready, stall_o, mem_ce});
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_store_load_word();
    do_req(MEM_OP_SW, 32'h10, 32'h1234_5678);
    n_checks++;
    if (r_we !== 2) begin n_fail++; $display("FAIL sw_we_cycles: got %0d want 2", r_we); end
    n_checks++;
    if (r_sel !== 4'b1111) begin n_fail++; $display("FAIL sw_sel: got %b want 1111", r_sel); end
    n_checks++;
    if (r_mwd !== 32'h1234_5678) begin
      n_fail++; $display("FAIL sw_wdata: got %h want 12345678", r_mwd);
    end
    n_checks++;
    if (r_resp !== 1 || r_lat !== 3 || r_data !== 32'h0) begin
      n_fail++; $display("FAIL sw_resp: got n=%0d lat=%0d data=%h want n=1 lat=3 data=0",
                         r_resp, r_lat, r_data);
    end
    n_checks++;
    if (r_busy !== 3 || r_stall_low !== 0) begin
      n_fail++; $display("FAIL sw_stall: got busy=%0d stall_low=%0d want 3/0", r_busy, r_stall_low);
    end
    do_req(MEM_OP_LW, 32'h10, 32'h0);
    n_checks++;
    if (r_lat !== 3 || r_data !== 32'h1234_5678) begin
      n_fail++; $display("FAIL lw_resp: got lat=%0d data=%h want lat=3 data=12345678",
                         r_lat, r_data);
    end
    n_checks++;
    if (r_we !== 0 || r_sel !== 4'b1111 || r_ce !== 2) begin
      n_fail++; $display("FAIL lw_strobes: got we=%0d sel=%b ce=%0d want 0/1111/2",
                         r_we, r_sel, r_ce);
    end
  endtask

  task automatic test_byte_store();
    do_req(MEM_OP_SB, 32'h11, 32'h0000_00AB);
    n_checks++;
    if (r_sel !== 4'b0100 || r_mwd !== 32'hABAB_ABAB) begin
      n_fail++; $display("FAIL sb_lanes: got sel=%b wdata=%h want 0100/ababab", r_sel, r_mwd);
    end
    do_req(MEM_OP_LW, 32'h10, 32'h0);
    n_checks++;
    if (r_data !== 32'h12AB_5678) begin
      n_fail++; $display("FAIL sb_readback: got %h want 12ab5678", r_data);
    end
  endtask

  task automatic test_loads();
    logic [3:0]  ops  [5] = '{MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LB};
    logic [31:0] adrs [5] = '{32'h11, 32'h11, 32'h12, 32'h10, 32'h13};
    logic [31:0] exps [5] = '{32'hFFFF_FFAB, 32'h0000_00AB, 32'h0000_5678, 32'h0000_12AB,
                              32'h0000_0078};
    for (int i = 0; i < 5; i++) begin
      do_req(ops[i], adrs[i], 32'h0);
      n_checks++;
      if (r_data !== exps[i] || r_lat !== 3) begin
        n_fail++; $display("FAIL load_align[%0d]: got data=%h lat=%0d want %h lat=3",
                           i, r_data, r_lat, exps[i]);
      end
    end
  endtask

  task automatic test_half_store();
    do_req(MEM_OP_SH, 32'h12, 32'h0000_BEEF);
    n_checks++;
    if (r_sel !== 4'b0011 || r_mwd !== 32'hBEEF_BEEF) begin
      n_fail++; $display("FAIL sh_lanes: got sel=%b wdata=%h want 0011/beefbeef", r_sel, r_mwd);
    end
    do_req(MEM_OP_LH, 32'h12, 32'h0);
    n_checks++;
    if (r_data !== 32'hFFFF_BEEF) begin
      n_fail++; $display("FAIL lh_sext: got %h want ffffbeef", r_data);
    end
    n_checks++;
    if (mem_word[4] !== 32'h12AB_BEEF) begin
      n_fail++; $display("FAIL sh_word: got %h want 12abbeef", mem_word[4]);
    end
  endtask

  task automatic test_misaligned();
    do_req(MEM_OP_LW, 32'h13, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    n_checks++;
    if (r_err !== 1 || r_ce !== 0 || r_resp !== 0 || r_busy !== 1) begin
      n_fail++; $display("FAIL misalign_err: got err=%0d ce=%0d resp=%0d busy=%0d want 1/0/0/1",
                         r_err, r_ce, r_resp, r_busy);
    end
`else
    n_checks++;
    if (r_err !== 0 || r_resp !== 1 || r_data !== 32'h12AB_BEEF) begin
      n_fail++; $display("FAIL misalign_pass: got err=%0d resp=%0d data=%h want 0/1/12abbeef",
                         r_err, r_resp, r_data);
    end
`endif
  endtask

  task automatic test_reset_abort();
    int resp_seen;
    resp_seen = 0;
    req_valid = 1'b1; req_op = MEM_OP_SW; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = MEM_OP_NONE;
    n_checks++;
    if ({mem_ce, mem_we} !== 2'b11) begin
      n_fail++; $display("FAIL abort_pre: got ce/we %b want 11", {mem_ce, mem_we});
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({mem_ce, mem_we, req_ready, stall_o} !== 4'b0010) begin
      n_fail++; $display("FAIL abort_drop: got ce/we/rdy/stall %b want 0010",
                         {mem_ce, mem_we, req_ready, stall_o});
    end
    @(posedge clk); @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (resp_valid) resp_seen++;
    end
    n_checks++;
    if (resp_seen !== 0) begin n_fail++; $display("FAIL abort_resp: got %0d want 0", resp_seen); end
    n_checks++;
    if (mem_word[4] !== 32'h12AB_BEEF) begin
      n_fail++; $display("FAIL abort_word: got %h want 12abbeef", mem_word[4]);
    end
  endtask

  task automatic test_back_to_back();
    int accepts, last, resps;
    accepts = 0; last = -1; resps = 0;
    b_valid = 1'b1; b_op = MEM_OP_LW; b_addr = 32'h20; b_wdata = 32'h0;
    for (int c = 0; c < 12; c++) begin
      if (b_ready) begin
        accepts++;
        if (last >= 0) begin
          n_checks++;
          if (c - last !== 3) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d want 3", c - last);
          end
        end
        last = c;
      end
      if (b_ce || b_resp_valid) begin
        n_checks++;
        if (b_ready !== 1'b0 || b_stall !== 1'b1) begin
          n_fail++; $display("FAIL b2b_ready: got rdy=%b stall=%b want 0/1", b_ready, b_stall);
        end
      end
      if (b_ce) begin
        n_checks++;
        if (b_mem_addr !== 32'h20 || b_sel !== 4'b1111 || b_we !== 1'b0 || b_mem_wdata !== 0
            || b_err !== 1'b0) begin
          n_fail++; $display("FAIL b2b_bus: got addr=%h sel=%b we=%b wd=%h err=%b want 20/1111/0/0/0",
                             b_mem_addr, b_sel, b_we, b_mem_wdata, b_err);
        end
      end
      if (b_resp_valid) begin
        resps++;
        n_checks++;
        if (b_resp_data !== 32'hCAFE_F00D) begin
          n_fail++; $display("FAIL b2b_data: got %h want cafef00d", b_resp_data);
        end
      end
      @(posedge clk); #1;
    end
    b_valid = 1'b0; b_op = MEM_OP_NONE;
    n_checks++;
    if (accepts !== 4 || resps !== 4) begin
      n_fail++; $display("FAIL b2b_count: got acc=%0d resp=%0d want 4/4", accepts, resps);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_none_op();
    test_store_load_word();
    test_byte_store();
    test_loads();
    test_half_store();
    test_misaligned();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
